// File: rtl/boot_ram_pkg.sv
// Shared definitions for the boot_ram program memory and its boot-loader FSM.
package boot_ram_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_LOAD  = 2'd0,
    ST_CHK   = 2'd1,
    ST_RUN   = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

endpackage

// File: rtl/boot_ram_dp_mem.sv
// One-write / one-async-read word array; contents are deliberately not reset
// so a program survives a reset of the surrounding loader.
module dp_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Write port: single synchronous write per cycle.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/boot_ram.sv
// Program RAM with a boot-loader FSM that fills memory from a valid/ready stream
// while holding the CPU in reset. Optional checksum stage: BOOT_RAM_CHECKSUM_EN.
module boot_ram
  import boot_ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              reload,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              cpu_run,
  output logic [ADDR_W:0]   load_cnt,
  output logic              err
);

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'((2**ADDR_W) - 1);

`ifdef BOOT_RAM_CHECKSUM_EN
  localparam state_e LOAD_EXIT = ST_CHK;
`else
  localparam state_e LOAD_EXIT = ST_RUN;
`endif

  state_e              state_q, state_d;
  logic [ADDR_W:0]     load_cnt_q, load_cnt_d;
  logic                cpu_run_q, ld_ready_q;
  logic                accept_s, mem_we_s;
  logic [ADDR_W-1:0]   mem_waddr_s;
  logic [DATA_W-1:0]   mem_wdata_s;
`ifdef BOOT_RAM_CHECKSUM_EN
  logic [DATA_W-1:0]   xsum_q, xsum_d;
  logic                err_q;
`endif

  assign accept_s = ld_valid && ld_ready_q && (state_q == ST_LOAD);

  // Next-state, load counter and write-port mux (loader owns the port in LOAD).
  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    mem_we_s    = 1'b0;
    mem_waddr_s = wr_addr;
    mem_wdata_s = wr_data;
`ifdef BOOT_RAM_CHECKSUM_EN
    xsum_d      = xsum_q;
`endif
    case (state_q)
      ST_LOAD: begin
        if (accept_s) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = load_cnt_q[ADDR_W-1:0];
          mem_wdata_s = ld_data;
          load_cnt_d  = load_cnt_q + (ADDR_W+1)'(1);
`ifdef BOOT_RAM_CHECKSUM_EN
          xsum_d      = xsum_q ^ ld_data;
`endif
          // A full memory ends the load even without ld_last, so index 0 is never reused.
          if (ld_last || (load_cnt_q == LAST_IDX)) begin
            state_d = LOAD_EXIT;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_RUN: begin
        mem_we_s = we;
        if (reload) begin
          state_d    = ST_LOAD;
          load_cnt_d = '0;
`ifdef BOOT_RAM_CHECKSUM_EN
          xsum_d     = '0;
`endif
        end else begin
          state_d = ST_RUN;
        end
      end
`ifdef BOOT_RAM_CHECKSUM_EN
      ST_CHK: begin
        if (ld_valid && ld_ready_q) begin
          state_d = (ld_data == xsum_q) ? ST_RUN : ST_ERROR;
        end else begin
          state_d = ST_CHK;
        end
      end
      ST_ERROR: begin
        if (reload) begin
          state_d    = ST_LOAD;
          load_cnt_d = '0;
          xsum_d     = '0;
        end else begin
          state_d = ST_ERROR;
        end
      end
`endif
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // State register; handshake outputs are registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_LOAD;
      load_cnt_q <= '0;
      cpu_run_q  <= 1'b0;
      ld_ready_q <= 1'b0;
`ifdef BOOT_RAM_CHECKSUM_EN
      xsum_q     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      cpu_run_q  <= (state_d == ST_RUN);
      ld_ready_q <= (state_d == ST_LOAD) || (state_d == ST_CHK);
`ifdef BOOT_RAM_CHECKSUM_EN
      xsum_q     <= xsum_d;
      err_q      <= (state_d == ST_ERROR);
`endif
    end
  end

  dp_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we_s),
    .waddr_i (mem_waddr_s),
    .wdata_i (mem_wdata_s),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign cpu_run  = cpu_run_q;
  assign ld_ready = ld_ready_q;
  assign load_cnt = load_cnt_q;
`ifdef BOOT_RAM_CHECKSUM_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/boot_ram.md
Name: boot_ram

Overview:
Parametrised successor to the fixed 16x8 program RAM used by the 4-bit CPU.
- Generalised width and depth.
- Adds a boot-loader state machine that fills memory from a valid/ready byte stream while holding the CPU in reset, then releases it.
- Sits between the board-level loader (UART/button bridge) and the CPU fetch and write ports.

Parameters:
DATA_W, 8, memory word width in bits
ADDR_W, 4, address width; depth = 2**ADDR_W words

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
ld_valid  in  1  loader word valid
ld_ready  out  1  block accepts loader word this cycle
ld_data  in  DATA_W  loader word
ld_last  in  1  marks final program word (qualified by ld_valid)
reload  in  1  one-cycle pulse: return to LOAD from RUN
rd_addr  in  ADDR_W  CPU read (fetch) address
rd_data  out  DATA_W  CPU read data, combinational from rd_addr
we  in  1  CPU write enable
wr_addr  in  ADDR_W  CPU write address
wr_data  in  DATA_W  CPU write data
cpu_run  out  1  1 = CPU may run; drive CPU active-low reset with it
load_cnt  out  ADDR_W+1  words written in current/last load
err  out  1  load checksum error (see Optional Feature)

Behaviour:
- States: LOAD, CHK (only with macro), RUN, ERROR (only with macro).
- Reset (async, any state, incl. mid-load):
  - state=LOAD, cpu_run=0, ld_ready=1 (next cycle after reset deasserts), load_cnt=0, err=0.
  - Memory contents are NOT cleared.
- LOAD:
  - ld_ready=1.
  - On ld_valid&&ld_ready: mem[load_cnt[ADDR_W-1:0]] <= ld_data; load_cnt++.
  - Exit when the accepted word has ld_last=1, or when it is word 2**ADDR_W-1 (full). Full takes effect even without ld_last; no wrap-around, so word 0 is never overwritten.
  - Exit target is RUN, or CHK with the macro.
  - CPU we ignored in LOAD; rd_data still valid (debug).
- RUN:
  - cpu_run=1, ld_ready=0.
  - CPU write: we=1 writes mem[wr_addr] on clk edge.
  - Read is combinational; read-during-write to the same address returns old data until the edge.
  - reload=1: next state LOAD, load_cnt<=0, cpu_run=0 from the next cycle. A CPU write in that same cycle still commits.
- Latency:
  - cpu_run rises the cycle after the last word is accepted (no checksum) or after the checksum is accepted (with checksum).
  - ld_ready drops in the same cycle that cpu_run rises.
- load_cnt holds its final value in RUN/ERROR; range 1..2**ADDR_W.
- Simultaneous ld_valid and reload in RUN: reload wins; the word is not accepted (ld_ready=0).

Optional Feature:
Macro BOOT_RAM_CHECKSUM_EN.
- Defined:
  - Running XOR of all accepted words, width DATA_W, cleared on entering LOAD.
  - After the final word, state CHK with ld_ready=1 accepts one more word as checksum (ld_last ignored).
  - Match → RUN.
  - Mismatch → ERROR: cpu_run=0, ld_ready=0, err=1. Only reset or reload leaves ERROR, returning to LOAD with err cleared.
- Not defined: CHK/ERROR absent; err tied 0; LOAD goes straight to RUN.

Decomposition:
- Package boot_ram_pkg: state encoding constants (LOAD, CHK, RUN, ERROR); 2-bit state width.
- One sub-module, dp_mem: parametrised 1-write/1-async-read array (DATA_W, ADDR_W).
  - Write-port mux (loader vs CPU) and FSM stay in boot_ram.

Test Plan:
- Load 3 words 0x11,0x22,0x33 (ld_last on 0x33) → load_cnt=3, cpu_run=1 one cycle after; rd_addr=1 → rd_data=0x22.
- Load 16 words 0x00..0x0F with no ld_last → transition to RUN after word 15, load_cnt=16, mem[0] still 0x00 (no wrap).
- In RUN, we=1 wr_addr=2 wr_data=0xA5 → rd_addr=2 reads old 0x33 same cycle, 0xA5 after edge; we during LOAD → no change.
- Assert reset after 2 of 3 words → cpu_run=0, load_cnt=0, ld_ready=1; previously written words retained; reload in RUN → cpu_run=0 next cycle, reload of 1 word works.
- BOOT_RAM_CHECKSUM_EN: words 0x0F,0xF0 then checksum 0xFF → RUN.
- BOOT_RAM_CHECKSUM_EN: same words then checksum 0x00 → err=1, cpu_run=0; reload clears err.
